// File: rtl/dsi_lane_hs_sequencer.sv
// dsi_lane_hs_sequencer
// Sequences the LP-to-HS entry and HS-to-LP exit of a MIPI DSI data lane
// around every high-speed burst, and grants the requester a payload window.
//
// Ports:
//   I_clk        byte clock (only clock)
//   RST          asynchronous active-high reset
//   I_hs_req     level request for an HS burst (sampled in IDLE only)
//   I_hs_done    last payload byte on the bus (sampled in DATA only)
//   O_hs_rdy     requester may drive payload bytes
//   O_sync       one-cycle pulse: output stage sends sync byte 0xB8
//   O_hs_oe      HS driver enable
//   O_hs_zero    output stage forces HS-0 (zero and trail phases)
//   O_lp_dp/dn   data-lane LP line levels
//   O_busy       sequencer not in IDLE
//   O_clk_lp_p/n, O_clk_hs_oe  clock-lane control (DSI_SEQ_CLK_LANE_EN only)
//
// Build option: define DSI_SEQ_CLK_LANE_EN to also sequence the clock lane.
// Without it the clock lane is assumed continuous HS and owned elsewhere.
// All timing parameters are in byte-clock cycles; a value of 0 acts as 1.

module dsi_lane_hs_sequencer #(
  parameter logic [7:0] T_LPX        = 8'd4,
  parameter logic [7:0] T_HS_PREPARE = 8'd3,
  parameter logic [7:0] T_HS_ZERO    = 8'd10,
  parameter logic [7:0] T_HS_TRAIL   = 8'd5,
  parameter logic [7:0] T_HS_EXIT    = 8'd6
`ifdef DSI_SEQ_CLK_LANE_EN
  ,
  parameter logic [7:0] T_CLK_PREPARE = 8'd3,
  parameter logic [7:0] T_CLK_ZERO    = 8'd20,
  parameter logic [7:0] T_CLK_PRE     = 8'd2,
  parameter logic [7:0] T_CLK_POST    = 8'd8,
  parameter logic [7:0] T_CLK_TRAIL   = 8'd4
`endif
) (
  input  logic I_clk,
  input  logic RST,
  input  logic I_hs_req,
  input  logic I_hs_done,
  output logic O_hs_rdy,
  output logic O_sync,
  output logic O_hs_oe,
  output logic O_hs_zero,
  output logic O_lp_dp,
  output logic O_lp_dn,
  output logic O_busy
`ifdef DSI_SEQ_CLK_LANE_EN
  ,
  output logic O_clk_lp_p,
  output logic O_clk_lp_n,
  output logic O_clk_hs_oe
`endif
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LP01,
    S_LP00,
    S_HS_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL,
    S_EXIT
`ifdef DSI_SEQ_CLK_LANE_EN
    ,
    S_CLK_LP01,
    S_CLK_LP00,
    S_CLK_ZERO,
    S_CLK_PRE,
    S_CLK_POST,
    S_CLK_TRAIL
`endif
  } state_t;

  typedef struct packed {
    logic hs_rdy;
    logic sync;
    logic hs_oe;
    logic hs_zero;
    logic lp_dp;
    logic lp_dn;
    logic busy;
`ifdef DSI_SEQ_CLK_LANE_EN
    logic clk_lp_p;
    logic clk_lp_n;
    logic clk_hs_oe;
`endif
  } outs_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  outs_t              outs;

  // Counter preload for a timed state: duration-1, with 0 treated as 1.
  function automatic logic [CNT_W-1:0] dur(input logic [7:0] p);
    return (p == 8'd0) ? CNT_W'(0) : CNT_W'(p - 8'd1);
  endfunction

  function automatic logic [CNT_W-1:0] load(input state_t s);
    case (s)
      S_LP01:      return dur(T_LPX);
      S_LP00:      return dur(T_HS_PREPARE);
      S_HS_ZERO:   return dur(T_HS_ZERO);
      S_TRAIL:     return dur(T_HS_TRAIL);
      S_EXIT:      return dur(T_HS_EXIT);
`ifdef DSI_SEQ_CLK_LANE_EN
      S_CLK_LP01:  return dur(T_LPX);
      S_CLK_LP00:  return dur(T_CLK_PREPARE);
      S_CLK_ZERO:  return dur(T_CLK_ZERO);
      S_CLK_PRE:   return dur(T_CLK_PRE);
      S_CLK_POST:  return dur(T_CLK_POST);
      S_CLK_TRAIL: return dur(T_CLK_TRAIL);
`endif
      default:     return CNT_W'(0);
    endcase
  endfunction

  // Transition function; timed states leave when the counter hits 0.
  function automatic state_t next_state(input state_t s, input logic [CNT_W-1:0] c,
                                        input logic req, input logic done);
    logic last;
    last = (c == CNT_W'(0));
    case (s)
`ifdef DSI_SEQ_CLK_LANE_EN
      S_IDLE:      return req ? S_CLK_LP01 : S_IDLE;
      S_CLK_LP01:  return last ? S_CLK_LP00 : s;
      S_CLK_LP00:  return last ? S_CLK_ZERO : s;
      S_CLK_ZERO:  return last ? S_CLK_PRE : s;
      S_CLK_PRE:   return last ? S_LP01 : s;
      S_TRAIL:     return last ? S_CLK_POST : s;
      S_CLK_POST:  return last ? S_CLK_TRAIL : s;
      S_CLK_TRAIL: return last ? S_EXIT : s;
`else
      S_IDLE:      return req ? S_LP01 : S_IDLE;
      S_TRAIL:     return last ? S_EXIT : s;
`endif
      S_LP01:      return last ? S_LP00 : s;
      S_LP00:      return last ? S_HS_ZERO : s;
      S_HS_ZERO:   return last ? S_SYNC : s;
      S_SYNC:      return S_DATA;
      S_DATA:      return done ? S_TRAIL : S_DATA;
      S_EXIT:      return last ? S_IDLE : s;
      default:     return S_IDLE;
    endcase
  endfunction

  // Reload on every state change, otherwise count down and hold at 0.
  function automatic logic [CNT_W-1:0] next_cnt(input state_t s, input logic [CNT_W-1:0] c,
                                                input logic req, input logic done);
    state_t nx;
    nx = next_state(s, c, req, done);
    if (nx != s) return load(nx);
    return (c == CNT_W'(0)) ? CNT_W'(0) : c - CNT_W'(1);
  endfunction

  // Output decode of a state; registered against the state it is entered with.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o       = '0;
    o.lp_dp = 1'b1;
    o.lp_dn = 1'b1;
    o.busy  = (s != S_IDLE);
`ifdef DSI_SEQ_CLK_LANE_EN
    o.clk_lp_p = 1'b1;
    o.clk_lp_n = 1'b1;
`endif
    case (s)
      S_LP01:    begin o.lp_dp = 1'b0; end
      S_LP00:    begin o.lp_dp = 1'b0; o.lp_dn = 1'b0; end
      S_HS_ZERO,
      S_TRAIL:   begin o.lp_dp = 1'b0; o.lp_dn = 1'b0; o.hs_oe = 1'b1; o.hs_zero = 1'b1; end
      S_SYNC:    begin o.lp_dp = 1'b0; o.lp_dn = 1'b0; o.hs_oe = 1'b1; o.sync = 1'b1; end
      S_DATA:    begin o.lp_dp = 1'b0; o.lp_dn = 1'b0; o.hs_oe = 1'b1; o.hs_rdy = 1'b1; end
      default:   ;
    endcase
`ifdef DSI_SEQ_CLK_LANE_EN
    // Clock lane is HS from CLK_ZERO until CLK_TRAIL ends, LP elsewhere.
    case (s)
      S_CLK_LP01: o.clk_lp_p = 1'b0;
      S_CLK_LP00: begin o.clk_lp_p = 1'b0; o.clk_lp_n = 1'b0; end
      S_IDLE,
      S_EXIT:     ;
      default:    begin o.clk_lp_p = 1'b0; o.clk_lp_n = 1'b0; o.clk_hs_oe = 1'b1; end
    endcase
`endif
    return o;
  endfunction

  // Sequencer state, phase counter and registered outputs.
  always_ff @(posedge I_clk or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      outs  <= decode(S_IDLE);
    end else begin
      state <= next_state(state, cnt, I_hs_req, I_hs_done);
      cnt   <= next_cnt(state, cnt, I_hs_req, I_hs_done);
      outs  <= decode(next_state(state, cnt, I_hs_req, I_hs_done));
    end
  end

  assign O_hs_rdy  = outs.hs_rdy;
  assign O_sync    = outs.sync;
  assign O_hs_oe   = outs.hs_oe;
  assign O_hs_zero = outs.hs_zero;
  assign O_lp_dp   = outs.lp_dp;
  assign O_lp_dn   = outs.lp_dn;
  assign O_busy    = outs.busy;
`ifdef DSI_SEQ_CLK_LANE_EN
  assign O_clk_lp_p  = outs.clk_lp_p;
  assign O_clk_lp_n  = outs.clk_lp_n;
  assign O_clk_hs_oe = outs.clk_hs_oe;
`endif

endmodule
